// File: rtl/multi_edge_detector.sv
// Per-channel synchronizer, optional debounce filter, registered edge pulses and sticky pending flags.
// Define MULTI_EDGE_DETECTOR_DEBOUNCE_EN to build the per-channel debounce filter in.
module multi_edge_detector #(
  parameter int N_CHANNELS      = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CHANNELS-1:0] in,
  input  logic [N_CHANNELS-1:0] enable,
  input  logic [N_CHANNELS-1:0] clear,
  output logic [N_CHANNELS-1:0] level,
  output logic [N_CHANNELS-1:0] positive_edge,
  output logic [N_CHANNELS-1:0] negative_edge,
  output logic                  any_edge,
  output logic [N_CHANNELS-1:0] pending
);

  logic [SYNC_STAGES-1:0][N_CHANNELS-1:0] sync_r;
  logic [N_CHANNELS-1:0]                  sync_s;
  logic [N_CHANNELS-1:0]                  level_r;
  logic [N_CHANNELS-1:0]                  prev_r;
  logic [N_CHANNELS-1:0]                  pos_r;
  logic [N_CHANNELS-1:0]                  neg_r;
  logic [N_CHANNELS-1:0]                  pending_r;
  logic                                   any_r;
  logic [N_CHANNELS-1:0]                  pos_s;
  logic [N_CHANNELS-1:0]                  neg_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Synchronizer chain; stage 0 samples the raw asynchronous inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], in};
    end
  end

`ifdef MULTI_EDGE_DETECTOR_DEBOUNCE_EN
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r [N_CHANNELS];

  // A changed level is accepted only once it has persisted DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_r <= '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CHANNELS; i++) begin
        if (sync_s[i] == level_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          level_r[i] <= sync_s[i];
          cnt_r[i]   <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  // Without the filter the last synchronizer stage is the accepted level.
  assign level_r = sync_s;
`endif

  assign pos_s = level_r & ~prev_r & enable;
  assign neg_s = ~level_r & prev_r & enable;

  // Edge pulses, their OR, and sticky pending flags where a new edge beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r    <= '0;
      pos_r     <= '0;
      neg_r     <= '0;
      any_r     <= 1'b0;
      pending_r <= '0;
    end else begin
      prev_r    <= level_r;
      pos_r     <= pos_s;
      neg_r     <= neg_s;
      any_r     <= |(pos_s | neg_s);
      pending_r <= (pending_r & ~clear) | pos_r | neg_r;
    end
  end

  assign level         = level_r;
  assign positive_edge = pos_r;
  assign negative_edge = neg_r;
  assign any_edge      = any_r;
  assign pending       = pending_r;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector: directed vector table, hand-written corner
// sequences and randomized traffic checked against a cycle-history reference model.
module tb_multi_edge_detector;
  localparam int N    = 4;
  localparam int S    = 2;
  localparam int D    = 4;
  localparam int MAXC = 1500;
`ifdef MULTI_EDGE_DETECTOR_DEBOUNCE_EN
  localparam int DB = D;
`else
  localparam int DB = 0;
`endif
  localparam int GLITCH_POS = (DB > 0) ? 0 : 1;
  localparam int GLITCH_LVL = (DB > 0) ? 0 : 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in, enable, clear;
  logic [N-1:0] level, positive_edge, negative_edge, pending;
  logic         any_edge;

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;

  logic [N-1:0] in_h [MAXC];
  logic [N-1:0] en_h [MAXC];
  logic [N-1:0] clr_h [MAXC];
  logic         rst_h [MAXC];
  logic [N-1:0] lvl_h [MAXC];
  logic [N-1:0] pos_h [MAXC];
  logic [N-1:0] neg_h [MAXC];
  logic [N-1:0] pend_h [MAXC];

  int pos_cnt [N];
  int neg_cnt [N];
  int lvl_hi [N];
  int any_cnt, pos_full_cnt, pos_part_cnt;

  typedef struct {
    logic [N-1:0] in;
    logic [N-1:0] en;
    logic [N-1:0] clr;
    logic [N-1:0] lvl;
    logic [N-1:0] pos;
    logic [N-1:0] neg;
    logic         any;
    logic [N-1:0] pend;
  } vec_t;

  vec_t vecs [13];

  multi_edge_detector #(
    .N_CHANNELS(N),
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(in),
    .enable(enable),
    .clear(clear),
    .level(level),
    .positive_edge(positive_edge),
    .negative_edge(negative_edge),
    .any_edge(any_edge),
    .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] lvl_at(int e);
    return (e < 0) ? '0 : lvl_h[e];
  endfunction

  function automatic logic rst_at(int e);
    return (e < 0) ? 1'b1 : rst_h[e];
  endfunction

  // Value that has travelled S sampling edges without an intervening reset.
  function automatic logic [N-1:0] raw_at(int e);
    if (e - S + 1 < 0) return '0;
    for (int k = e - S + 1; k <= e; k++) begin
      if (rst_h[k]) return '0;
    end
    return in_h[e - S + 1];
  endfunction

  function automatic void model_update(int e);
    logic [N-1:0] lv, pl, r;
    logic flip;
    if (rst_h[e]) begin
      lvl_h[e] = '0; pos_h[e] = '0; neg_h[e] = '0; pend_h[e] = '0;
    end else begin
      pl = lvl_at(e - 1);
      if (DB == 0) begin
        lv = raw_at(e);
      end else begin
        lv = pl;
        for (int i = 0; i < N; i++) begin
          flip = 1'b1;
          for (int j = 1; j <= DB; j++) begin
            r = raw_at(e - j);
            if (e - j < 0 || r[i] == pl[i]) flip = 1'b0;
          end
          if (flip) lv[i] = ~pl[i];
        end
      end
      lvl_h[e] = lv;
      if (rst_at(e - 1)) begin
        pos_h[e] = '0;
        neg_h[e] = '0;
      end else begin
        pos_h[e] = pl & ~lvl_at(e - 2) & en_h[e];
        neg_h[e] = ~pl & lvl_at(e - 2) & en_h[e];
      end
      if (e == 0) pend_h[e] = '0;
      else pend_h[e] = (pend_h[e-1] & ~clr_h[e]) | pos_h[e-1] | neg_h[e-1];
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, t, act, exp);
    end
  endtask

  task automatic clear_counts();
    for (int b = 0; b < N; b++) begin
      pos_cnt[b] = 0; neg_cnt[b] = 0; lvl_hi[b] = 0;
    end
    any_cnt = 0; pos_full_cnt = 0; pos_part_cnt = 0;
  endtask

  task automatic step(input logic [N-1:0] i_in, input logic [N-1:0] i_en,
                      input logic [N-1:0] i_clr, input logic i_rst);
    @(negedge clk);
    in = i_in; enable = i_en; clear = i_clr; rst = i_rst;
    @(posedge clk);
    if (t >= MAXC) begin
      $display("FAIL history_overflow at cycle %0d: got %0d, expected below %0d", t, t, MAXC);
      $fatal(1, "history overflow");
    end
    in_h[t] = i_in; en_h[t] = i_en; clr_h[t] = i_clr; rst_h[t] = i_rst;
    model_update(t);
    #1;
    check("model_level", 32'(level), 32'(lvl_h[t]));
    check("model_pos", 32'(positive_edge), 32'(pos_h[t]));
    check("model_neg", 32'(negative_edge), 32'(neg_h[t]));
    check("model_any", 32'(any_edge), 32'(|(pos_h[t] | neg_h[t])));
    check("model_pending", 32'(pending), 32'(pend_h[t]));
    for (int b = 0; b < N; b++) begin
      if (positive_edge[b]) pos_cnt[b]++;
      if (negative_edge[b]) neg_cnt[b]++;
      if (level[b]) lvl_hi[b]++;
    end
    if (any_edge) any_cnt++;
    if (positive_edge == 4'b1111) pos_full_cnt++;
    else if (positive_edge != 4'b0000) pos_part_cnt++;
    t++;
  endtask

  initial begin
    logic [N-1:0] cur_in, r_en, r_clr;
    logic         r_rst;
    int           found;

    rst = 1'b1; in = '0; enable = '0; clear = '0;
    clear_counts();

    vecs[0]  = '{4'b0001, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000};
    vecs[1]  = '{4'b0001, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000};
    vecs[2]  = '{4'b0001, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0000};
    vecs[3]  = '{4'b0001, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001};
    vecs[4]  = '{4'b0000, 4'b1111, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000};
    vecs[5]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000};
    vecs[6]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 4'b0000};
    vecs[7]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001};
    vecs[8]  = '{4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001};
    vecs[9]  = '{4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0001};
    vecs[10] = '{4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b0001};
    vecs[11] = '{4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b1111};
    vecs[12] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0001};

    step(4'b0000, 4'b1111, 4'b0000, 1'b1);
    step(4'b0000, 4'b1111, 4'b0000, 1'b1);
    check("reset_state", 32'({level, positive_edge, negative_edge, any_edge, pending}), 32'd0);

`ifndef MULTI_EDGE_DETECTOR_DEBOUNCE_EN
    // Exact-latency vectors for the unfiltered build.
    for (int v = 0; v < 13; v++) begin
      step(vecs[v].in, vecs[v].en, vecs[v].clr, 1'b0);
      check("vec_level", 32'(level), 32'(vecs[v].lvl));
      check("vec_pos", 32'(positive_edge), 32'(vecs[v].pos));
      check("vec_neg", 32'(negative_edge), 32'(vecs[v].neg));
      check("vec_any", 32'(any_edge), 32'(vecs[v].any));
      check("vec_pending", 32'(pending), 32'(vecs[v].pend));
    end
`endif

    // All channels rising together.
    for (int k = 0; k < 14; k++) step(4'b0000, 4'b1111, 4'b1111, 1'b0);
    clear_counts();
    for (int k = 0; k < 14; k++) step(4'b1111, 4'b1111, 4'b0000, 1'b0);
    check("all_rise_full", 32'(pos_full_cnt), 32'd1);
    check("all_rise_partial", 32'(pos_part_cnt), 32'd0);
    check("all_rise_any", 32'(any_cnt), 32'd1);

    // Edge while disabled is discarded, re-enabling creates nothing.
    for (int k = 0; k < 3; k++) step(4'b1111, 4'b1111, 4'b1111, 1'b0);
    clear_counts();
    for (int k = 0; k < 14; k++) step(4'b1011, 4'b1011, 4'b0000, 1'b0);
    for (int k = 0; k < 8; k++) step(4'b1011, 4'b1111, 4'b0000, 1'b0);
    check("disabled_neg2", 32'(neg_cnt[2]), 32'd0);
    check("disabled_pending2", 32'(pending[2]), 32'd0);

    // Set and clear of pending in the same cycle, then clear alone.
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      step(4'b0011, 4'b1111, 4'b0000, 1'b0);
      if (negative_edge[3]) found = 1;
    end
    check("setclr_pulse_seen", 32'(found), 32'd1);
    step(4'b0011, 4'b1111, 4'b1000, 1'b0);
    check("setclr_set_wins", 32'(pending[3]), 32'd1);
    step(4'b0011, 4'b1111, 4'b1000, 1'b0);
    check("setclr_cleared", 32'(pending[3]), 32'd0);

    // Short glitch, then a sustained pulse, on channel 1.
    for (int k = 0; k < 12; k++) step(4'b0001, 4'b1111, 4'b0000, 1'b0);
    clear_counts();
    for (int k = 0; k < 3; k++) step(4'b0011, 4'b1111, 4'b0000, 1'b0);
    for (int k = 0; k < 12; k++) step(4'b0001, 4'b1111, 4'b0000, 1'b0);
    check("glitch_pos1", 32'(pos_cnt[1]), 32'(GLITCH_POS));
    check("glitch_level1", 32'(lvl_hi[1]), 32'(GLITCH_LVL));
    clear_counts();
    for (int k = 0; k < 10; k++) step(4'b0011, 4'b1111, 4'b0000, 1'b0);
    for (int k = 0; k < 12; k++) step(4'b0001, 4'b1111, 4'b0000, 1'b0);
    check("held_pos1", 32'(pos_cnt[1]), 32'd1);
    check("held_neg1", 32'(neg_cnt[1]), 32'd1);

    // Reset in the middle of propagation/debounce with the input held high.
    for (int k = 0; k < 12; k++) step(4'b0000, 4'b1111, 4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) step(4'b0001, 4'b1111, 4'b0000, 1'b0);
    step(4'b0001, 4'b1111, 4'b0000, 1'b1);
    check("midreset_outputs", 32'({level, positive_edge, negative_edge, any_edge, pending}), 32'd0);
    clear_counts();
    for (int k = 0; k < 16; k++) step(4'b0001, 4'b1111, 4'b0000, 1'b0);
    check("midreset_pos0", 32'(pos_cnt[0]), 32'd1);

    // Randomized traffic against the reference model.
    cur_in = in;
    for (int k = 0; k < 500; k++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) cur_in[b] = ~cur_in[b];
      end
      r_en  = ($urandom_range(3) == 0) ? N'($urandom) : 4'b1111;
      r_clr = N'($urandom) & N'($urandom);
      r_rst = ($urandom_range(99) == 0);
      step(cur_in, r_en, r_clr, r_rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
